// File: rtl/seq_ripple_adder.sv
// seq_ripple_adder: chunked multi-cycle add/sub with registered inter-chunk carry and valid/ready handshakes
module seq_ripple_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t r_state, w_next;
   logic [IW-1:0] r_idx;
   logic r_carry, r_cout, r_ovf;
   logic [WIDTH-1:0] r_a, r_b, r_sum;
   logic [CHUNK-1:0] w_ak, w_bk;
   logic [CHUNK:0] w_full;
   logic w_cmsb, w_last;
   assign w_ak = r_a[int'(r_idx)*CHUNK +: CHUNK];
   assign w_bk = r_b[int'(r_idx)*CHUNK +: CHUNK];
   assign w_full = {1'b0, w_ak} + {1'b0, w_bk} + {{CHUNK{1'b0}}, r_carry};
   // carry into the chunk MSB recovered from the MSB sum bit; equals r_carry when CHUNK=1
   assign w_cmsb = w_full[CHUNK-1] ^ w_ak[CHUNK-1] ^ w_bk[CHUNK-1];
   assign w_last = r_idx == IW'(NCHUNK - 1);
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE && in_valid) w_next = RUN;
      else if (r_state == RUN && w_last) w_next = DONE;
      else if (r_state == DONE && out_ready) w_next = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= '0;
         r_carry <= 1'b0;
         r_sum <= '0;
         r_cout <= 1'b0;
         r_ovf <= 1'b0;
      end else if (r_state == IDLE && in_valid) begin
         r_a <= a;
         r_b <= sub ? ~b : b;
         r_carry <= sub | cin;
         r_idx <= '0;
         r_sum <= '0;
      end else if (r_state == RUN) begin
         r_sum[int'(r_idx)*CHUNK +: CHUNK] <= w_full[CHUNK-1:0];
         r_carry <= w_full[CHUNK];
         r_idx <= r_idx + IW'(1);
         if (w_last) begin
            r_cout <= w_full[CHUNK];
            r_ovf <= w_full[CHUNK] ^ w_cmsb;
         end
      end
   end
   assign in_ready = r_state == IDLE;
   assign out_valid = r_state == DONE;
   assign busy = r_state == RUN || r_state == DONE;
   assign sum = r_sum;
   assign cout = r_cout;
   assign ovf = r_ovf;
endmodule

// File: doc/seq_ripple_adder.md
Name: seq_ripple_adder

Overview:
Parametrised, multi-cycle successor to the 4-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first. The carry is registered between chunks, which trades latency for a short critical path. It provides valid/ready handshakes on input and output, signed-overflow detection, and an add/subtract mode. It sits between operand-producing logic and any arithmetic consumer in the datapath.

Parameters:
WIDTH, 16, operand and result width in bits; must be ≥ 1.
CHUNK, 4, bits summed per cycle; WIDTH must be an integer multiple of CHUNK; CHUNK = WIDTH gives a single-cycle pass.
NCHUNK (localparam), WIDTH/CHUNK, number of chunk cycles per operation.

Ports:
clk        input   1      clock; all state updates on its rising edge
rst        input   1      synchronous reset, active-high
in_valid   input   1      operand set present on a, b, cin, sub
in_ready   output  1      block can accept operands
a          input   WIDTH  operand A
b          input   WIDTH  operand B
cin        input   1      carry-in; ignored when sub=1
sub        input   1      0: A+B+cin; 1: A−B (computed as A+~B+1)
out_valid  output  1      result fields valid and held stable
out_ready  input   1      consumer takes the result
sum        output WIDTH   result
cout       output  1      carry out of the MSB (for sub: 1 = no borrow)
ovf        output  1      signed overflow = carry into MSB XOR carry out of MSB
busy       output  1      high in RUN or DONE

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk and rst as named above.
- FSM states: IDLE, RUN, DONE.
- Reset (rst=1 at an edge, from any state, including mid-RUN or in DONE):
  - state → IDLE; chunk index, carry register, sum, cout and ovf → 0.
  - out_valid=0, busy=0, in_ready=1.
  - Any in-flight operation is discarded with no output.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, a and b are latched. If sub=1, the block stores ~b and sets carry = 1; otherwise it stores b and sets carry = cin.
  - Chunk index → 0, state → RUN, sum cleared to 0.
- RUN:
  - in_ready=0, busy=1.
  - Each edge computes chunk k = index, i.e. bits [k·CHUNK +: CHUNK] = A_k + B'_k + carry, with a CHUNK-bit ripple inside the chunk.
  - The chunk result is written into sum and the carry register takes the chunk carry-out; index increments.
  - On the edge that computes chunk NCHUNK−1:
    - cout = final carry-out.
    - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1. Both come from the last chunk's internal ripple; for WIDTH=1 the carry into the MSB is the initial carry.
    - state → DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable while out_ready=0.
  - On an edge with out_valid=1 and out_ready=1: state → IDLE, out_valid → 0.
  - in_ready is not asserted in the same cycle as the output transfer; a new operation is accepted at the earliest one cycle later.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge. Minimum issue interval is NCHUNK+2 cycles with out_ready held at 1.
- in_valid, a, b, cin and sub are ignored whenever in_ready=0. Changing the inputs during RUN does not affect the result.
- Between operations, sum, cout and ovf keep the last result until the next accept clears sum. out_valid is the only qualifier for these fields.
- Arithmetic is modulo 2^WIDTH. Wrap-around is flagged by cout (unsigned) and ovf (signed); there is no saturation.

Test Plan:
1. Reset, then a=0xFFFF, b=0x0001, cin=0, sub=0 → out_valid exactly 4 cycles after accept; sum=0x0000, cout=1, ovf=0.
2. a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x0001, sub=1, cin=1 (ignored) → sum=0x7FFF, cout=1, ovf=1.
3. Backpressure: complete an operation with out_ready=0 for 5 cycles → sum, cout, ovf and out_valid stable; in_ready=0 and busy=1. Raise out_ready → IDLE next cycle; in_ready=1 one cycle after the transfer.
4. Busy-input rejection: accept a=0x1234, b=0x1111; pulse in_valid with a=0xFFFF during RUN → sum=0x2345, cout=0, ovf=0; the second operand set is never accepted.
5. Reset mid-operation: assert rst on the 2nd RUN cycle → next cycle IDLE, in_ready=1, out_valid=0, busy=0; a following a=0x0003, b=0x0004 gives sum=0x0007.
6. Config sweep: WIDTH=16 with CHUNK=16, 8, 1 → latencies of 1, 2 and 16 cycles. 1000 random operands and modes per configuration must match a reference model on sum, cout and ovf.
